// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder
// Responder end of the MemoryBus read protocol. Aligned 64-bit read requests
// are queued in order. Each one is answered with a read or error response
// after a fixed latency, measured from the moment the entry becomes queue head.
// The word array can be preloaded through a simple write port. Its contents
// survive reset.
module instruction_memory_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4,
    parameter int BUS_ID_W    = 8,
    localparam int WORD_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [63:0]         req_addr,
    input  logic [BUS_ID_W-1:0] req_bus_id,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [1:0]          resp_type,
    output logic [63:0]         resp_payload,
    output logic [BUS_ID_W-1:0] resp_bus_id,
    input  logic                wr_en,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [63:0]         wr_data,
    output logic [31:0]         stat_reads,
    output logic [31:0]         stat_errors
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] TYPE_READ  = 2'd1;
    localparam logic [1:0] TYPE_ERROR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_PRESENT
    } state_t;

    // The error decision is made once, at accept time. This way the queue only
    // has to hold the word index, not the full byte address.
    typedef struct packed {
        logic                err;
        logic [WORD_W-1:0]   word;
        logic [BUS_ID_W-1:0] id;
    } entry_t;

    logic [63:0] mem [MEM_WORDS];
    logic [63:0] rd_data_q;

    entry_t slot_q [QUEUE_DEPTH];
    entry_t new_entry;
    entry_t head;

    state_t               state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 req_ready_q, req_ready_d;
    logic [1:0]           resp_type_q, resp_type_d;
    logic [BUS_ID_W-1:0]  resp_bus_id_q, resp_bus_id_d;
    logic [31:0]          stat_reads_q, stat_reads_d;
    logic [31:0]          stat_errors_q, stat_errors_d;
    logic                 push;
    logic                 pop;
    logic                 load_resp;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push = req_valid && req_ready_q;
    assign pop  = (state_q == ST_PRESENT) && resp_ready;
    assign head = slot_q[rd_ptr_q];

    assign new_entry.err  = (req_addr[2:0] != 3'b000) ||
                            (req_addr[63:3] >= 61'(MEM_WORDS));
    assign new_entry.word = req_addr[WORD_W+2:3];
    assign new_entry.id   = req_bus_id;

    // Next-state logic for the queue bookkeeping, the head FSM, the
    // registered response fields and the statistics.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_resp     = 1'b0;
        resp_type_d   = resp_type_q;
        resp_bus_id_d = resp_bus_id_q;
        stat_reads_d  = stat_reads_q;
        stat_errors_d = stat_errors_q;

        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        req_ready_d = (count_d < CNT_W'(QUEUE_DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (push) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d       = ST_PRESENT;
                    load_resp     = 1'b1;
                    resp_type_d   = head.err ? TYPE_ERROR : TYPE_READ;
                    resp_bus_id_d = head.id;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            ST_PRESENT: begin
                if (resp_ready) begin
                    if (resp_type_q == TYPE_ERROR) begin
                        stat_errors_d = stat_errors_q + 32'd1;
                    end else begin
                        stat_reads_d = stat_reads_q + 32'd1;
                    end
                    if (count_d != '0) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_W'(LATENCY - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers. Reset flushes the queue and clears the
    // statistics at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_type_q   <= 2'd0;
            resp_bus_id_q <= '0;
            stat_reads_q  <= '0;
            stat_errors_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            req_ready_q   <= req_ready_d;
            resp_type_q   <= resp_type_d;
            resp_bus_id_q <= resp_bus_id_d;
            stat_reads_q  <= stat_reads_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    // Queue payload storage. No reset is needed, because only entries below
    // count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q] <= new_entry;
        end
    end

    // Word array with preload port and a registered read.
    // A preload write to the word being fetched on the same edge is not seen.
    // The read returns the old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_word] <= wr_data;
        end
        if (load_resp) begin
            rd_data_q <= mem[head.word];
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = (state_q == ST_PRESENT);
    assign resp_type    = resp_type_q;
    assign resp_bus_id  = resp_bus_id_q;
    assign resp_payload = (resp_type_q == TYPE_READ) ? rd_data_q : 64'd0;
    assign stat_reads   = stat_reads_q;
    assign stat_errors  = stat_errors_q;

endmodule
